// File: rtl/grid_state_writer.sv
// grid_state_writer: writer side of the 32-bit display_state bus.
//   It debounces the step and fire buttons, moves a 4x4 cursor, resolves shots
//   against target_map and records them in a shadow grid. The shadow is copied
//   to display_state only on frame_start, so the picture never changes mid-frame.
//
//   Optional feature macro: GRID_CURSOR_OVERLAY_EN
//     defined   : the cursor cell reads 11 at commit, and cursor moves set pending
//     undefined : display_state is exactly the shadow grid
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     btn_step, btn_fire    raw (bouncy, asynchronous) buttons
//     sw_axis, sw_dir_n     step axis (0 row / 1 col), direction (0 +1 / 1 -1)
//     clear                 sync level; wipes grid, counters, cursor
//     target_map[15:0]      ship present per cell, index = row*4+col
//     frame_start           commit strobe (1 clk at vsync start)
//     display_state[31:0]   committed grid, cell i = bits [2i+1:2i]
//     cursor_row/col        current cursor
//     updated               1-clk pulse, visible with the new display_state
//     fire_err              1-clk pulse, shot at an already-resolved cell
//     hit_count[4:0]        resolved hits, saturating at 31
//     game_over             sticky, hit_count >= SHIP_CELLS

// Per-button input path: 2-FF sync, stability counter, rising-edge event.
// evt is high in the cycle after the accepted level rises, so logic that
// consumes it acts DB_CYCLES+3 clocks after the raw input settled.
module grid_btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic evt
);
  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             lvl_dly_q;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    lvl_d  = lvl_q;
    cnt_d  = '0;
    // any sample equal to the accepted level restarts the run of new-level samples
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) lvl_d = sync_q[1];
      else                                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
    end
  end

  assign evt = lvl_q & ~lvl_dly_q;
endmodule

module grid_state_writer #(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int SHIP_CELLS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_step,
  input  logic        btn_fire,
  input  logic        sw_axis,
  input  logic        sw_dir_n,
  input  logic        clear,
  input  logic [15:0] target_map,
  input  logic        frame_start,
  output logic [31:0] display_state,
  output logic [1:0]  cursor_row,
  output logic [1:0]  cursor_col,
  output logic        updated,
  output logic        fire_err,
  output logic [4:0]  hit_count,
  output logic        game_over
);
  localparam logic [1:0] C_UNK = 2'b00, C_MISS = 2'b01, C_HIT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE} state_e;

  // button 0 = step, button 1 = fire
  logic [1:0] btn_raw, btn_evt;
  assign btn_raw = {btn_fire, btn_step};

  for (genvar g = 0; g < 2; g++) begin : g_db
    grid_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[g]),
      .evt    (btn_evt[g])
    );
  end

  state_e          state_q, state_d;
  logic [15:0][1:0] shadow_q, shadow_d;
  logic [15:0][1:0] disp_q, disp_d, disp_next;
  logic [1:0]      row_q, row_d, col_q, col_d;
  logic            pending_q, pending_d;
  logic            tgt_q, tgt_d;
  logic            updated_q, updated_d;
  logic            fire_err_q, fire_err_d;
  logic [4:0]      hit_q, hit_d;
  logic            go_q, go_d;
  logic [3:0]      cur_idx;

  assign cur_idx = {row_q, col_q};

  // image that a commit this cycle would publish
  always_comb begin
    disp_next = shadow_q;
`ifdef GRID_CURSOR_OVERLAY_EN
    disp_next[cur_idx] = 2'b11;
`endif
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    disp_d     = disp_q;
    row_d      = row_q;
    col_d      = col_q;
    pending_d  = pending_q;
    tgt_d      = tgt_q;
    updated_d  = 1'b0;
    fire_err_d = 1'b0;
    hit_d      = hit_q;

    // commit first so a WRITE in the same cycle re-arms pending for the next frame
    if (frame_start && pending_q) begin
      disp_d    = disp_next;
      pending_d = 1'b0;
      updated_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (btn_evt[0]) begin
          if (sw_axis) col_d = sw_dir_n ? col_q - 2'd1 : col_q + 2'd1;
          else         row_d = sw_dir_n ? row_q - 2'd1 : row_q + 2'd1;
`ifdef GRID_CURSOR_OVERLAY_EN
          pending_d = 1'b1;
`endif
        end
        if (btn_evt[1] && !go_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (shadow_q[cur_idx] != C_UNK) begin
          fire_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tgt_d   = target_map[cur_idx];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        shadow_d[cur_idx] = tgt_q ? C_HIT : C_MISS;
        if (tgt_q && hit_q != 5'd31) hit_d = hit_q + 5'd1;
        pending_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    go_d = go_q | (int'(hit_d) >= SHIP_CELLS);

    // clear overrides everything, including a commit in the same cycle
    if (clear) begin
      state_d    = S_IDLE;
      shadow_d   = '0;
      disp_d     = disp_q;
      row_d      = 2'd0;
      col_d      = 2'd0;
      pending_d  = 1'b1;
      updated_d  = 1'b0;
      fire_err_d = 1'b0;
      hit_d      = 5'd0;
      go_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      disp_q     <= '0;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      pending_q  <= 1'b0;
      tgt_q      <= 1'b0;
      updated_q  <= 1'b0;
      fire_err_q <= 1'b0;
      hit_q      <= 5'd0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pending_q  <= pending_d;
      tgt_q      <= tgt_d;
      updated_q  <= updated_d;
      fire_err_q <= fire_err_d;
      hit_q      <= hit_d;
      go_q       <= go_d;
    end
  end

  assign display_state = disp_q;
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign updated       = updated_q;
  assign fire_err      = fire_err_q;
  assign hit_count     = hit_q;
  assign game_over     = go_q;
endmodule
